// File: rtl/sdf_pkg.sv
// ---------------------------------------------------------------------------
// sdf_pkg -- shared types and helpers for the radix-2 DIF SDF FFT pipeline
// stage controllers.
//
// Contents:
//   sdf_state_e          controller state (IDLE, FILL, RUN, DRAIN)
//   SEL_PHASE_A/B        butterfly / delay-line mux select encodings
//   clog2()              ceiling log2 for elaboration-time sizing
//   sdf_delay()          delay-line depth D = 2^(LOG2N-STAGE-1)
//   sdf_cnt_w()          per-block sample counter width (counts 0..2D-1)
// ---------------------------------------------------------------------------
package sdf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } sdf_state_e;

    // Phase A: fill the delay line / emit the delayed difference.
    // Phase B: butterfly between the delayed sample and the incoming one.
    localparam logic SEL_PHASE_A = 1'b0;
    localparam logic SEL_PHASE_B = 1'b1;

    localparam int LOG2N_MIN = 2;
    localparam int LOG2N_MAX = 10;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic int sdf_delay(input int log2n, input int stage);
        return 1 << (log2n - stage - 1);
    endfunction

    function automatic int sdf_cnt_w(input int log2n, input int stage);
        return log2n - stage;
    endfunction

endpackage

// File: rtl/sdf_twiddle_addr.sv
// ---------------------------------------------------------------------------
// sdf_twiddle_addr -- maps the in-block position of a sample to the twiddle
// exponent k of W_N^k for one SDF stage. Purely combinational so that the
// same mapping can drive both the controller output and a ROM address.
//
// Ports:
//   j       in   J_W        sample index within the half block (0..D-1)
//   phase   in   1          SEL_PHASE_A / SEL_PHASE_B
//   tw_idx  out  LOG2N-1    k = j << STAGE in phase A, 0 in phase B
// ---------------------------------------------------------------------------
module sdf_twiddle_addr
    import sdf_pkg::*;
#(
    parameter int LOG2N = 5,
    parameter int STAGE = 3,
    parameter int J_W   = 1
) (
    input  logic [J_W-1:0]   j,
    input  logic             phase,
    output logic [LOG2N-2:0] tw_idx
);

    localparam int TW_W = LOG2N - 1;

    // j < 2^(LOG2N-STAGE-1), so j << STAGE always fits in TW_W bits.
    logic [TW_W-1:0] j_ext;
    assign j_ext  = TW_W'(j);
    assign tw_idx = (phase == SEL_PHASE_B) ? '0 : (j_ext << STAGE);

endmodule

// File: rtl/sdf_stage_ctrl.sv
// ---------------------------------------------------------------------------
// sdf_stage_ctrl -- generic per-stage controller for a radix-2 DIF
// single-path delay-feedback FFT. Works for any stage of a 2^LOG2N FFT,
// tolerates input stalls, ends a burst on last_i with a self-timed drain of
// the delay line, and exposes a ready handshake.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   valid_i, last_i        input sample valid / final sample of the burst
//   data_in_r, data_in_i   signed input sample (IN_W bits)
//   ready_o                sample accepted this cycle when valid_i is high
//   valid_o                butterfly output valid
//   sel_o                  0 = phase A (fill/emit diff), 1 = phase B
//   shift_en_o             delay-line advance enable
//   tw_idx_o               twiddle exponent k of W_N^k
//   data_out_r, data_out_i registered, sign-extended input (IN_W+1 bits)
//   err_o                  sticky protocol error (misplaced last_i)
// All outputs are registered; they reflect an accepted sample one cycle later.
// ---------------------------------------------------------------------------
module sdf_stage_ctrl
    import sdf_pkg::*;
#(
    parameter int LOG2N = 5,
    parameter int STAGE = 3,
    parameter int IN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic              last_i,
    input  logic [IN_W-1:0]   data_in_r,
    input  logic [IN_W-1:0]   data_in_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic              sel_o,
    output logic              shift_en_o,
    output logic [LOG2N-2:0]  tw_idx_o,
    output logic [IN_W:0]     data_out_r,
    output logic [IN_W:0]     data_out_i,
    output logic              err_o
);

    localparam int D     = sdf_delay(LOG2N, STAGE);
    localparam int CNT_W = sdf_cnt_w(LOG2N, STAGE);
    localparam int J_W   = (clog2(D) > 0) ? clog2(D) : 1;

    // Last sample of the fill half (cnt == D-1) and of the block (2D-1).
    localparam logic [CNT_W-1:0] CNT_HALF_END  = CNT_W'(D - 1);
    localparam logic [CNT_W-1:0] CNT_BLOCK_END = {CNT_W{1'b1}};

    sdf_state_e       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             accept;
    logic             phase;
    logic [J_W-1:0]   j;
    logic [LOG2N-2:0] tw_calc;

    logic             ready_n, valid_n, sel_n, shift_n, err_n;
    logic [LOG2N-2:0] tw_n;
    logic [IN_W:0]    dout_r_n, dout_i_n;

    // ready_o is low only while draining, so no sample is taken in DRAIN.
    assign accept = valid_i & ready_o;
    assign phase  = cnt[CNT_W-1];

    generate
        if (CNT_W > 1) begin : g_j
            assign j = cnt[J_W-1:0];
        end else begin : g_j_single
            // D = 1: the half block has a single slot.
            assign j = '0;
        end
    endgenerate

    sdf_twiddle_addr #(
        .LOG2N (LOG2N),
        .STAGE (STAGE),
        .J_W   (J_W)
    ) u_twiddle_addr (
        .j      (j),
        .phase  (phase),
        .tw_idx (tw_calc)
    );

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; an incomplete assignment here would infer a latch.
        state_n  = state;
        cnt_n    = cnt;
        valid_n  = 1'b0;
        shift_n  = 1'b0;
        sel_n    = sel_o;
        tw_n     = tw_idx_o;
        dout_r_n = data_out_r;
        dout_i_n = data_out_i;
        err_n    = err_o;

        if (accept) begin
            cnt_n    = cnt + CNT_W'(1);
            shift_n  = 1'b1;
            sel_n    = phase;
            tw_n     = tw_calc;
            dout_r_n = {data_in_r[IN_W-1], data_in_r};
            dout_i_n = {data_in_i[IN_W-1], data_in_i};
        end

        unique case (state)
            IDLE, FILL: begin
                if (accept) begin
                    // The first D samples only fill the delay line. With
                    // D = 1 the very first sample completes the fill.
                    state_n = (cnt == CNT_HALF_END) ? RUN : FILL;
                    if (last_i) begin
                        err_n = 1'b1;
                    end
                end
            end

            RUN: begin
                if (accept) begin
                    valid_n = 1'b1;
                    if (last_i) begin
                        // Only a block-aligned last_i ends the burst; cnt
                        // wraps to 0 naturally and is reused as drain j.
                        if (cnt == CNT_BLOCK_END) begin
                            state_n = DRAIN;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end
            end

            DRAIN: begin
                // Flush the delay line: D phase-A outputs with zero input.
                valid_n  = 1'b1;
                shift_n  = 1'b1;
                sel_n    = SEL_PHASE_A;
                tw_n     = tw_calc;
                dout_r_n = '0;
                dout_i_n = '0;
                cnt_n    = cnt + CNT_W'(1);
                if (cnt == CNT_HALF_END) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end

            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        ready_n = (state_n != DRAIN);
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            ready_o    <= 1'b1;
            valid_o    <= 1'b0;
            sel_o      <= 1'b0;
            shift_en_o <= 1'b0;
            tw_idx_o   <= '0;
            data_out_r <= '0;
            data_out_i <= '0;
            err_o      <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            ready_o    <= ready_n;
            valid_o    <= valid_n;
            sel_o      <= sel_n;
            shift_en_o <= shift_n;
            tw_idx_o   <= tw_n;
            data_out_r <= dout_r_n;
            data_out_i <= dout_i_n;
            err_o      <= err_n;
        end
    end

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sdf_stage_ctrl -- self-checking bench for sdf_stage_ctrl.
// Two instances: STAGE=3 (D=2) and STAGE=0 (D=16), both LOG2N=5, IN_W=16.
// Inputs change on the falling edge; outputs are sampled on the next
// falling edge and compared with a sample-count based reference model.
// ---------------------------------------------------------------------------
module tb_sdf_stage_ctrl;

    typedef struct {
        logic        ready;
        logic        valid;
        logic        sel;
        logic        shift;
        int          tw;
        logic [16:0] dr;
        logic [16:0] di;
        logic        err;
    } out_t;

    // Reference model: n = samples accepted in the current burst, drain_k =
    // drain cycles still to emit, drain_j = next drain slot, o = outputs
    // expected after the coming clock edge.
    typedef struct {
        int   n;
        int   drain_k;
        int   drain_j;
        out_t o;
    } mdl_t;

    typedef struct {
        logic v;
        logic l;
        logic e_valid;
        logic e_sel;
        int   e_tw;
        logic e_shift;
        logic e_ready;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        v3 = 0, l3 = 0, v0 = 0, l0 = 0;
    logic [15:0] r3 = '0, i3 = '0, r0 = '0, i0 = '0;

    logic        rdy3, val3, sel3, sh3, err3;
    logic [3:0]  tw3;
    logic [16:0] dr3, di3;
    logic        rdy0, val0, sel0, sh0, err0;
    logic [3:0]  tw0;
    logic [16:0] dr0, di0;

    int tests = 0;
    int fails = 0;

    mdl_t m3, m0;
    vec_t tbl[7];

    always #5 clk = ~clk;

    sdf_stage_ctrl #(.LOG2N(5), .STAGE(3), .IN_W(16)) u3 (
        .clk(clk), .rst_n(rst_n), .valid_i(v3), .last_i(l3),
        .data_in_r(r3), .data_in_i(i3), .ready_o(rdy3), .valid_o(val3),
        .sel_o(sel3), .shift_en_o(sh3), .tw_idx_o(tw3),
        .data_out_r(dr3), .data_out_i(di3), .err_o(err3)
    );

    sdf_stage_ctrl #(.LOG2N(5), .STAGE(0), .IN_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .valid_i(v0), .last_i(l0),
        .data_in_r(r0), .data_in_i(i0), .ready_o(rdy0), .valid_o(val0),
        .sel_o(sel0), .shift_en_o(sh0), .tw_idx_o(tw0),
        .data_out_r(dr0), .data_out_i(di0), .err_o(err0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.n = 0; m.drain_k = 0; m.drain_j = 0;
        m.o.ready = 1'b1; m.o.valid = 1'b0; m.o.sel = 1'b0; m.o.shift = 1'b0;
        m.o.tw = 0; m.o.dr = '0; m.o.di = '0; m.o.err = 1'b0;
        return m;
    endfunction

    // One clock of the reference model, written from the burst rules:
    // position in block = n mod 2D, first D samples of a burst produce no
    // output, a last_i is legal only on position 2D-1, then D drain slots.
    function automatic mdl_t mdl_next(input mdl_t m, input logic v, input logic l,
                                      input logic [15:0] r, input logic [15:0] i,
                                      input int d, input int stage);
        mdl_t x;
        int   pos;
        x = m;
        x.o.valid = 1'b0;
        x.o.shift = 1'b0;
        if (m.drain_k > 0) begin
            x.o.valid = 1'b1;
            x.o.shift = 1'b1;
            x.o.sel   = 1'b0;
            x.o.tw    = m.drain_j * (1 << stage);
            x.o.dr    = '0;
            x.o.di    = '0;
            x.drain_j = m.drain_j + 1;
            x.drain_k = m.drain_k - 1;
            if (x.drain_k == 0) begin
                x.o.ready = 1'b1;
                x.n       = 0;
            end
        end else if (v && m.o.ready) begin
            pos       = m.n % (2 * d);
            x.o.shift = 1'b1;
            x.o.sel   = (pos >= d);
            x.o.tw    = (pos >= d) ? 0 : pos * (1 << stage);
            x.o.valid = (m.n >= d);
            x.o.dr    = 17'($signed(r));
            x.o.di    = 17'($signed(i));
            x.n       = m.n + 1;
            if (l) begin
                if (pos == 2 * d - 1) begin
                    x.drain_k = d;
                    x.drain_j = 0;
                    x.o.ready = 1'b0;
                end else begin
                    x.o.err = 1'b1;
                end
            end
        end
        return x;
    endfunction

    function automatic out_t obs3();
        out_t o;
        o.ready = rdy3; o.valid = val3; o.sel = sel3; o.shift = sh3;
        o.tw = 32'(tw3); o.dr = dr3; o.di = di3; o.err = err3;
        return o;
    endfunction

    function automatic out_t obs0();
        out_t o;
        o.ready = rdy0; o.valid = val0; o.sel = sel0; o.shift = sh0;
        o.tw = 32'(tw0); o.dr = dr0; o.di = di0; o.err = err0;
        return o;
    endfunction

    task automatic cmp(input string p, input out_t a, input out_t e);
        check({p, ".ready"}, 32'(a.ready), 32'(e.ready));
        check({p, ".valid"}, 32'(a.valid), 32'(e.valid));
        check({p, ".sel"},   32'(a.sel),   32'(e.sel));
        check({p, ".shift"}, 32'(a.shift), 32'(e.shift));
        check({p, ".tw"},    a.tw,         e.tw);
        check({p, ".dr"},    32'(a.dr),    32'(e.dr));
        check({p, ".di"},    32'(a.di),    32'(e.di));
        check({p, ".err"},   32'(a.err),   32'(e.err));
    endtask

    // Called on a falling edge: drive both instances, step both models,
    // advance to the next falling edge and compare.
    task automatic tick(input logic va, input logic la, input logic vb, input logic lb);
        v3 = va; l3 = la; r3 = 16'($urandom); i3 = 16'($urandom);
        v0 = vb; l0 = lb; r0 = 16'($urandom); i0 = 16'($urandom);
        m3 = mdl_next(m3, va, la, r3, i3, 2, 3);
        m0 = mdl_next(m0, vb, lb, r0, i0, 16, 0);
        @(negedge clk);
        cmp("s3", obs3(), m3.o);
        cmp("s0", obs0(), m0.o);
    endtask

    // Called on a falling edge: asynchronous reset mid-cycle, outputs must
    // take reset values before any clock edge, release on the next fall.
    task automatic do_reset();
        v3 = 0; l3 = 0; v0 = 0; l0 = 0;
        #2;
        rst_n = 1'b0;
        #1;
        m3 = mdl_reset();
        m0 = mdl_reset();
        cmp("rst3", obs3(), m3.o);
        cmp("rst0", obs0(), m0.o);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic va, la, vb, lb;

        //            v  l  e_valid e_sel e_tw e_shift e_ready
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 8, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0};  // drain j=0
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 8, 1'b1, 1'b1};  // drain j=1, valid_i ignored
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b1};  // idle, sel/tw hold

        m3 = mdl_reset();
        m0 = mdl_reset();
        @(negedge clk);
        do_reset();

        // 1: four-sample burst on the D=2 stage, then drain
        for (int k = 0; k < 7; k++) begin
            tick(tbl[k].v, tbl[k].l, 1'b0, 1'b0);
            check($sformatf("t1.valid[%0d]", k), 32'(val3), 32'(tbl[k].e_valid));
            check($sformatf("t1.sel[%0d]", k),   32'(sel3), 32'(tbl[k].e_sel));
            check($sformatf("t1.tw[%0d]", k),    32'(tw3),  tbl[k].e_tw);
            check($sformatf("t1.shift[%0d]", k), 32'(sh3),  32'(tbl[k].e_shift));
            check($sformatf("t1.ready[%0d]", k), 32'(rdy3), 32'(tbl[k].e_ready));
        end
        check("t1.drain_data", 32'(dr3), 32'h0);

        // 2: 32 back-to-back samples, last on #32
        do_reset();
        for (int k = 1; k <= 32; k++) tick(1'b1, k == 32, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("t2.err", 32'(err3), 32'h0);
        check("t2.ready", 32'(rdy3), 32'h1);

        // 3: stall after sample #5, resume at cnt=1
        do_reset();
        for (int k = 1; k <= 5; k++) tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            check("t3.stall_valid", 32'(val3), 32'h0);
            check("t3.stall_shift", 32'(sh3), 32'h0);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        check("t3.resume_sel", 32'(sel3), 32'h0);
        check("t3.resume_tw", 32'(tw3), 32'h8);
        check("t3.resume_valid", 32'(val3), 32'h1);

        // 4: misplaced last on #6 sets sticky err, last on #8 drains
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            tick(1'b1, (k == 6) || (k == 8), 1'b0, 1'b0);
            if (k == 6) check("t4.err_set", 32'(err3), 32'h1);
            if (k == 7) check("t4.no_drain", 32'(rdy3), 32'h1);
        end
        check("t4.drain_ready", 32'(rdy3), 32'h0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("t4.err_sticky", 32'(err3), 32'h1);

        // 5: reset mid-RUN after sample #10, then restart in FILL
        do_reset();
        for (int k = 1; k <= 10; k++) tick(1'b1, 1'b0, 1'b0, 1'b0);
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        check("t5.fill0", 32'(val3), 32'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        check("t5.fill1", 32'(val3), 32'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        check("t5.run", 32'(val3), 32'h1);

        // 6: STAGE=0 (D=16), 32 samples with last, 16-cycle drain
        do_reset();
        for (int k = 1; k <= 32; k++) begin
            tick(1'b0, 1'b0, 1'b1, k == 32);
            if (k <= 16) check($sformatf("t6.tw_a[%0d]", k), 32'(tw0), k - 1);
            else         check($sformatf("t6.tw_b[%0d]", k), 32'(tw0), 32'h0);
        end
        for (int k = 0; k < 16; k++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            check($sformatf("t6.drain_tw[%0d]", k), 32'(tw0), k);
            check($sformatf("t6.drain_valid[%0d]", k), 32'(val0), 32'h1);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("t6.after_drain_valid", 32'(val0), 32'h0);
        check("t6.after_drain_ready", 32'(rdy0), 32'h1);

        // Randomized traffic on both instances against the model
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 400) == 0) begin
                do_reset();
            end
            va = ($urandom_range(0, 3) != 0);
            vb = ($urandom_range(0, 3) != 0);
            if (m3.drain_k == 0 && (m3.n % 4) == 3) la = 1'($urandom_range(0, 1));
            else                                    la = ($urandom_range(0, 30) == 0);
            if (m0.drain_k == 0 && (m0.n % 32) == 31) lb = 1'($urandom_range(0, 1));
            else                                      lb = ($urandom_range(0, 60) == 0);
            tick(va, la, vb, lb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
